branch_control_unit: RTL and testbench
======================================

BRANCH_CONTROL_UNIT -- requirements
Module: branch_control_unit

Interface
REQ-001 Parameter COUNT_WIDTH, default 32: width of each statistics counter.
REQ-002 CLK  input  1  single clock; all sequential logic updates on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 DATA1  input  32  first branch operand (rs1 value).
REQ-005 DATA2  input  32  second branch operand (rs2 value).
REQ-006 SELECT  input  4  branch control code; bit3 = branch/jump enable, bits[2:0] = condition.
REQ-007 PC_MUX_OUT  output  1  1 = redirect PC to the branch/jump target; 0 = PC+4.
REQ-008 BRANCH_COUNT  output  COUNT_WIDTH  number of cycles with SELECT[3]=1; present only with the macro in REQ-027.
REQ-009 TAKEN_COUNT  output  COUNT_WIDTH  number of cycles with PC_MUX_OUT=1; present only with the macro in REQ-027.

Function
REQ-010 PC_MUX_OUT shall be purely combinational from DATA1, DATA2 and SELECT, with no clock latency, and shall settle within 3 ns of any input change.
REQ-011 SELECT[3]=0 (any of 0000-0111) shall drive PC_MUX_OUT=0.
REQ-012 SELECT=1000 (BEQ) shall drive PC_MUX_OUT=1 iff DATA1==DATA2.
REQ-013 SELECT=1001 (BNE) shall drive PC_MUX_OUT=1 iff DATA1!=DATA2.
REQ-014 SELECT=1010 (JAL/JALR) shall drive PC_MUX_OUT=1 unconditionally.
REQ-015 SELECT=1011 is reserved and shall drive PC_MUX_OUT=0.
REQ-016 SELECT=1100 (BLT) shall drive PC_MUX_OUT=1 iff DATA1<DATA2, both operands as 32-bit two's complement.
REQ-017 SELECT=1101 (BGE) shall drive PC_MUX_OUT=1 iff DATA1>=DATA2 signed, and 1 when operands are equal.
REQ-018 SELECT=1110 (BLTU) shall drive PC_MUX_OUT=1 iff DATA1<DATA2 unsigned.
REQ-019 SELECT=1111 (BGEU) shall drive PC_MUX_OUT=1 iff DATA1>=DATA2 unsigned, and 1 when operands are equal.
REQ-020 The signed comparison shall be correct at the extremes: 0x80000000 < 0x7FFFFFFF signed, and 0x80000000 > 0x7FFFFFFF unsigned.
REQ-021 Any X or Z on SELECT shall not be masked; PC_MUX_OUT is unspecified in that case.
REQ-022 With stats enabled, each rising CLK edge shall increment BRANCH_COUNT when SELECT[3]=1 and shall increment TAKEN_COUNT when PC_MUX_OUT=1; both increments shall occur in the same edge.
REQ-023 Counters shall wrap from all-ones to 0 with no saturation and no flag.

Reset
REQ-024 RESET=0 shall clear BRANCH_COUNT and TAKEN_COUNT to 0 immediately, independent of CLK.
REQ-025 While RESET=0 the counters shall hold at 0; the first increment shall occur on the first rising edge after RESET returns to 1.
REQ-026 PC_MUX_OUT is combinational and shall remain valid during reset.

Configuration
REQ-027 Macro BRANCH_CONTROL_UNIT_STATS_EN: when defined, the counters and ports BRANCH_COUNT and TAKEN_COUNT shall exist.
REQ-028 When BRANCH_CONTROL_UNIT_STATS_EN is undefined, BRANCH_COUNT, TAKEN_COUNT and all sequential logic shall be omitted.
REQ-029 When BRANCH_CONTROL_UNIT_STATS_EN is undefined, CLK and RESET shall remain as ports but shall be unused.

Verification
REQ-030 SELECT=1010, DATA1=5, DATA2=7 -> PC_MUX_OUT=1; SELECT=1000 with the same operands -> 0; SELECT=1000 with 214/214 -> 1.
REQ-031 BNE: 689/689 -> 0; 43543/6566 -> 1. SELECT=0011 or 1011 with any operands -> 0.
REQ-032 Signed: BLT 0x1/0xFFFFFFFF -> 0; BLT 0xFFFFFFFF/0x1 -> 1; BGE 0xFFFFFFFF/0x1 -> 0; BGE 0x1/0xFFFFFFFF -> 1; BGE 7/7 -> 1.
REQ-033 Unsigned: BLTU 0xFFFFFFFF/0x1 -> 0; BLTU 0x1/0xFFFFFFFF -> 1; BGEU 0x1/0xFFFFFFFF -> 0; BGEU 0xFFFFFFFF/0x1 -> 1.
REQ-034 Stats on: release RESET; apply 4 cycles BEQ taken, 2 cycles BNE not taken, 1 cycle SELECT=0000 -> BRANCH_COUNT=6, TAKEN_COUNT=4.
REQ-035 Stats on: assert RESET=0 mid-cycle -> both counters read 0 before the next CLK edge.

Source files
------------

// File: rtl/branch_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_control_unit
// Brief    : Branch/jump resolution for a RISC-V style PC mux, with optional
//            branch statistics counters enabled by BRANCH_CONTROL_UNIT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_control_unit #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            DATA1,
  input  logic [31:0]            DATA2,
  input  logic [3:0]             SELECT,
  output logic                   PC_MUX_OUT
`ifdef BRANCH_CONTROL_UNIT_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] BRANCH_COUNT,
  output logic [COUNT_WIDTH-1:0] TAKEN_COUNT
`endif
);

  localparam logic [3:0] c_sel_beq  = 4'b1000;
  localparam logic [3:0] c_sel_bne  = 4'b1001;
  localparam logic [3:0] c_sel_jal  = 4'b1010;
  localparam logic [3:0] c_sel_rsvd = 4'b1011;
  localparam logic [3:0] c_sel_blt  = 4'b1100;
  localparam logic [3:0] c_sel_bge  = 4'b1101;
  localparam logic [3:0] c_sel_bltu = 4'b1110;
  localparam logic [3:0] c_sel_bgeu = 4'b1111;

  logic w_eq;
  logic w_lt_signed;
  logic w_lt_unsigned;
  logic w_taken;

  assign w_eq          = (DATA1 == DATA2);
  assign w_lt_signed   = ($signed(DATA1) < $signed(DATA2));
  assign w_lt_unsigned = (DATA1 < DATA2);

  // Every legal code is listed so an unknown SELECT falls to default and
  // propagates X instead of being silently resolved to "not taken".
  always_comb begin
    w_taken = 1'b0;
    case (SELECT)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110, 4'b0111: w_taken = 1'b0;
      c_sel_beq:  w_taken = w_eq;
      c_sel_bne:  w_taken = ~w_eq;
      c_sel_jal:  w_taken = 1'b1;
      c_sel_rsvd: w_taken = 1'b0;
      c_sel_blt:  w_taken = w_lt_signed;
      c_sel_bge:  w_taken = ~w_lt_signed;
      c_sel_bltu: w_taken = w_lt_unsigned;
      c_sel_bgeu: w_taken = ~w_lt_unsigned;
      default:    w_taken = 1'bx;
    endcase
  end

  assign PC_MUX_OUT = w_taken;

`ifdef BRANCH_CONTROL_UNIT_STATS_EN
  logic [COUNT_WIDTH-1:0] r_branch_count;
  logic [COUNT_WIDTH-1:0] r_taken_count;

  // Counters wrap naturally at all-ones.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_branch_count <= '0;
      r_taken_count  <= '0;
    end else begin
      if (SELECT[3]) r_branch_count <= r_branch_count + 1'b1;
      if (w_taken)   r_taken_count  <= r_taken_count + 1'b1;
    end
  end

  assign BRANCH_COUNT = r_branch_count;
  assign TAKEN_COUNT  = r_taken_count;
`else
  // Clock, reset and counter width are intentionally unused in this build.
  logic w_unused;
  assign w_unused = ^{CLK, RESET, (COUNT_WIDTH > 0)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_control_unit
// Brief    : Directed self-checking bench for branch_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  sel;
  logic        pc_mux;
`ifdef BRANCH_CONTROL_UNIT_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] taken_count;
`endif

  int checks   = 0;
  int failures = 0;

  branch_control_unit #(.COUNT_WIDTH(32)) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .DATA1        (data1),
    .DATA2        (data2),
    .SELECT       (sel),
    .PC_MUX_OUT   (pc_mux)
`ifdef BRANCH_CONTROL_UNIT_STATS_EN
    ,
    .BRANCH_COUNT (branch_count),
    .TAKEN_COUNT  (taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic vec(input string tag, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] b, input logic exp);
    sel   = s;
    data1 = a;
    data2 = b;
    #1;
    chk(tag, {31'd0, pc_mux}, {31'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 4'b0000;
    data1 = 32'd0;
    data2 = 32'd0;
    #2;
`ifdef BRANCH_CONTROL_UNIT_STATS_EN
    chk("reset_branch_count", branch_count, 32'd0);
    chk("reset_taken_count", taken_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sel = 4'b1000; data1 = 32'd214; data2 = 32'd214;
    repeat (4) @(negedge clk);
    chk("beq4_branch_count", branch_count, 32'd4);
    chk("beq4_taken_count", taken_count, 32'd4);
    sel = 4'b1001; data1 = 32'd689; data2 = 32'd689;
    repeat (2) @(negedge clk);
    sel = 4'b0000;
    @(negedge clk);
    chk("mix_branch_count", branch_count, 32'd6);
    chk("mix_taken_count", taken_count, 32'd4);
    // Mid-cycle asynchronous clear, observed before the next rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clr_branch", branch_count, 32'd0);
    chk("async_clr_taken", taken_count, 32'd0);
`endif
    // Combinational vectors run with reset asserted; output must stay valid.
    vec("jal_5_7",        4'b1010, 32'd5,        32'd7,        1'b1);
    vec("beq_5_7",        4'b1000, 32'd5,        32'd7,        1'b0);
    vec("beq_214_214",    4'b1000, 32'd214,      32'd214,      1'b1);
    vec("bne_689_689",    4'b1001, 32'd689,      32'd689,      1'b0);
    vec("bne_43543_6566", 4'b1001, 32'd43543,    32'd6566,     1'b1);
    vec("sel0011",        4'b0011, 32'd1,        32'd1,        1'b0);
    vec("sel0010",        4'b0010, 32'd3,        32'd9,        1'b0);
    vec("rsvd1011_eq",    4'b1011, 32'd9,        32'd9,        1'b0);
    vec("rsvd1011_ne",    4'b1011, 32'd9,        32'd4,        1'b0);
    vec("blt_1_m1",       4'b1100, 32'h1,        32'hFFFFFFFF, 1'b0);
    vec("blt_m1_1",       4'b1100, 32'hFFFFFFFF, 32'h1,        1'b1);
    vec("bge_m1_1",       4'b1101, 32'hFFFFFFFF, 32'h1,        1'b0);
    vec("bge_1_m1",       4'b1101, 32'h1,        32'hFFFFFFFF, 1'b1);
    vec("bge_7_7",        4'b1101, 32'd7,        32'd7,        1'b1);
    vec("blt_7_7",        4'b1100, 32'd7,        32'd7,        1'b0);
    vec("bltu_m1_1",      4'b1110, 32'hFFFFFFFF, 32'h1,        1'b0);
    vec("bltu_1_m1",      4'b1110, 32'h1,        32'hFFFFFFFF, 1'b1);
    vec("bgeu_1_m1",      4'b1111, 32'h1,        32'hFFFFFFFF, 1'b0);
    vec("bgeu_m1_1",      4'b1111, 32'hFFFFFFFF, 32'h1,        1'b1);
    vec("bgeu_eq",        4'b1111, 32'h1234,     32'h1234,     1'b1);
    vec("blt_min_max",    4'b1100, 32'h80000000, 32'h7FFFFFFF, 1'b1);
    vec("bltu_min_max",   4'b1110, 32'h80000000, 32'h7FFFFFFF, 1'b0);
    vec("bgeu_min_max",   4'b1111, 32'h80000000, 32'h7FFFFFFF, 1'b1);
    vec("bge_min_max",    4'b1101, 32'h80000000, 32'h7FFFFFFF, 1'b0);
`ifdef BRANCH_CONTROL_UNIT_STATS_EN
    chk("hold_in_reset_branch", branch_count, 32'd0);
    chk("hold_in_reset_taken", taken_count, 32'd0);
    // One taken BEQ after release, then one not-taken branch.
    @(negedge clk);
    sel = 4'b1000; data1 = 32'd3; data2 = 32'd3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_branch", branch_count, 32'd1);
    chk("post_reset_taken", taken_count, 32'd1);
    sel = 4'b1100; data1 = 32'd8; data2 = 32'd2;
    @(negedge clk);
    chk("nt_blt_branch", branch_count, 32'd2);
    chk("nt_blt_taken", taken_count, 32'd1);
    sel = 4'b0111;
    @(negedge clk);
    chk("nobranch_branch", branch_count, 32'd2);
    chk("nobranch_taken", taken_count, 32'd1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
